// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light family: light encodings, the
// controller state codes, and small elaboration-time helpers.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b10;
  localparam logic [1:0] GREEN  = 2'b11;

  typedef enum logic [2:0] {
    V_GREEN   = 3'd0,
    V_YELLOW  = 3'd1,
    ALL_RED_1 = 3'd2,
    H_GREEN   = 3'd3,
    H_YELLOW  = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  // The one code the enumeration leaves unused; the controller recovers from it.
  localparam logic [2:0] ST_ILLEGAL = 3'd7;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one controller phase. It stops at zero
// and can be frozen; expired flags the final cycle of the phase.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             expired
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default assignment first so every path drives count_d; no latch.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!hold && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: no reset branch here; the owner asserts load with the reset value
  // while its synchronous reset is active, so the counter is defined from then on.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for registered state avoids read/write races.
    count_q <= count_d;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/traffic_timed.sv
// Fixed-time two-way intersection controller with all-red clearance and an
// optional pedestrian walk phase served after the horizontal cycle.
module traffic_timed
  import traffic_pkg::*;
#(
  parameter int G_TICKS = 8,
  parameter int Y_TICKS = 3,
  parameter int R_TICKS = 1,
  parameter int W_TICKS = 5,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       ped_req,
  output logic [1:0] horizontal_light,
  output logic [1:0] vertical_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  localparam int MAX_TICKS = max4(G_TICKS, Y_TICKS, R_TICKS, W_TICKS);

  generate
    if (G_TICKS < 1 || Y_TICKS < 1 || R_TICKS < 1 || W_TICKS < 1) begin : g_bad_ticks
      $error("traffic_timed: every *_TICKS parameter must be at least 1");
    end
    if (longint'(MAX_TICKS - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
      $error("traffic_timed: CNT_W too narrow for the longest phase");
    end
  endgenerate

  logic [2:0]       state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             expired;
  logic             illegal;
  logic             advance;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;

  // Timer reload value for the phase being entered: its duration minus one.
  function automatic logic [CNT_W-1:0] ticks_of(input logic [2:0] st);
    logic [CNT_W-1:0] t;
    case (st)
      V_GREEN, H_GREEN:     t = CNT_W'(G_TICKS - 1);
      V_YELLOW, H_YELLOW:   t = CNT_W'(Y_TICKS - 1);
      ALL_RED_1, ALL_RED_2: t = CNT_W'(R_TICKS - 1);
      PED_WALK:             t = CNT_W'(W_TICKS - 1);
      default:              t = CNT_W'(G_TICKS - 1);
    endcase
    return t;
  endfunction

  // Recovery from the unused code ignores hold so the lights never stay dark.
  assign illegal = (state_q == ST_ILLEGAL);
  assign advance = illegal || (expired && !hold);

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        V_GREEN:   state_d = V_YELLOW;
        V_YELLOW:  state_d = ALL_RED_1;
        ALL_RED_1: state_d = H_GREEN;
        H_GREEN:   state_d = H_YELLOW;
        H_YELLOW:  state_d = ALL_RED_2;
        ALL_RED_2: state_d = ped_pending_q ? PED_WALK : V_GREEN;
        PED_WALK:  state_d = V_GREEN;
        default:   state_d = V_GREEN;
      endcase
    end
  end

  // Requests during a walk are already served by it; the clear on entering
  // the walk overrides a request arriving on that same edge.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (ped_req && (state_q != PED_WALK)) begin
      ped_pending_d = 1'b1;
    end
    if (advance && (state_q == ALL_RED_2) && ped_pending_q) begin
      ped_pending_d = 1'b0;
    end
  end

  assign timer_load     = !reset || advance;
  assign timer_load_val = reset ? ticks_of(state_d) : ticks_of(V_GREEN);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .load     (timer_load),
    .load_val (timer_load_val),
    .hold     (hold),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= V_GREEN;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Outputs decode registered state only, so they change cleanly at the edge.
  always_comb begin
    horizontal_light = RED;
    vertical_light   = RED;
    walk             = 1'b0;
    case (state_q)
      V_GREEN:  vertical_light   = GREEN;
      V_YELLOW: vertical_light   = YELLOW;
      H_GREEN:  horizontal_light = GREEN;
      H_YELLOW: horizontal_light = YELLOW;
      PED_WALK: walk             = 1'b1;
      default: begin
        horizontal_light = RED;
        vertical_light   = RED;
      end
    endcase
  end

  assign ped_pending = ped_pending_q;
  assign phase       = state_q;

endmodule

// File: tb/tb_traffic_timed.sv
// Directed bench for traffic_timed with G=4, Y=2, R=1, W=3; outputs are
// sampled on the falling edge, inputs change there too.
module tb_traffic_timed;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       ped_req;
  logic [1:0] horizontal_light;
  logic [1:0] vertical_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  traffic_timed #(
    .G_TICKS (4),
    .Y_TICKS (2),
    .R_TICKS (1),
    .W_TICKS (3),
    .CNT_W   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .hold             (hold),
    .ped_req          (ped_req),
    .horizontal_light (horizontal_light),
    .vertical_light   (vertical_light),
    .walk             (walk),
    .ped_pending      (ped_pending),
    .phase            (phase)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [1:0] exp_h(input int ph);
    case (ph)
      3:       return 2'b11;
      4:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_v(input int ph);
    case (ph)
      0:       return 2'b11;
      1:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Safety over the whole run: never two live directions, never walk under a live light.
  always @(negedge clk) begin
    if (started) begin
      check("safe_dirs", {31'd0, !((horizontal_light != 2'b00) && (vertical_light != 2'b00))}, 32'd1);
      check("safe_walk", {31'd0, !(walk && ((horizontal_light != 2'b00) || (vertical_light != 2'b00)))}, 32'd1);
    end
  end

  int exp_seq[14];

  initial begin
    exp_seq = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5};
    reset   = 1'b0;
    hold    = 1'b0;
    ped_req = 1'b0;

    // Reset state
    cyc();
    check("rst_phase", phase, 0);
    check("rst_h", horizontal_light, 2'b00);
    check("rst_v", vertical_light, 2'b11);
    check("rst_walk", walk, 0);
    check("rst_pend", ped_pending, 0);
    started = 1'b1;
    reset   = 1'b1;

    // Two free-running periods of 14 cycles
    for (int i = 0; i < 28; i++) begin
      check($sformatf("seq_phase[%0d]", i), phase, exp_seq[i % 14]);
      check($sformatf("seq_h[%0d]", i), horizontal_light, exp_h(exp_seq[i % 14]));
      check($sformatf("seq_v[%0d]", i), vertical_light, exp_v(exp_seq[i % 14]));
      check($sformatf("seq_walk[%0d]", i), walk, 0);
      cyc();
    end

    // Pedestrian pulse during H_GREEN
    check("p_start", phase, 0);
    repeat (7) cyc();
    check("p_hgreen", phase, 3);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    check("p_pending", ped_pending, 1);
    repeat (5) cyc();
    check("p_allred2", phase, 5);
    check("p_pend_ar2", ped_pending, 1);
    cyc();
    check("p_cleared", ped_pending, 0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("walk_phase[%0d]", k), phase, 6);
      check($sformatf("walk_on[%0d]", k), walk, 1);
      check($sformatf("walk_h[%0d]", k), horizontal_light, 2'b00);
      check($sformatf("walk_v[%0d]", k), vertical_light, 2'b00);
      cyc();
    end
    check("p_back_vg", phase, 0);
    check("p_back_walk", walk, 0);

    // Hold at timer=2 for 5 cycles: V_GREEN lasts 9 samples
    cyc();
    check("h_c1", phase, 0);
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("h_held[%0d]", k), phase, 0);
    end
    hold = 1'b0;
    cyc();
    check("h_after1", phase, 0);
    cyc();
    check("h_after2", phase, 0);
    cyc();
    check("h_vyellow", phase, 1);

    // Hold at timer=0 in V_YELLOW
    cyc();
    check("h0_c1", phase, 1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("h0_held[%0d]", k), phase, 1);
    end
    hold = 1'b0;
    cyc();
    check("h0_allred1", phase, 2);
    cyc();
    check("h0_hgreen", phase, 3);

    // Request on the ALL_RED_2 -> PED_WALK edge and during the walk
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    repeat (5) cyc();
    check("e_allred2", phase, 5);
    ped_req = 1'b1;
    cyc();
    check("e_walk", phase, 6);
    check("e_clear_wins", ped_pending, 0);
    cyc();
    check("e_ignored1", ped_pending, 0);
    cyc();
    check("e_ignored2", ped_pending, 0);
    cyc();
    ped_req = 1'b0;
    check("e_vgreen", phase, 0);
    check("e_pend_after", ped_pending, 0);
    repeat (13) cyc();
    check("e_ar2_again", phase, 5);
    cyc();
    check("e_one_walk", phase, 0);

    // Reset during PED_WALK, with hold and ped_req asserted
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    repeat (12) cyc();
    check("r_ar2", phase, 5);
    cyc();
    check("r_walk0", phase, 6);
    cyc();
    check("r_walk1", phase, 6);
    reset   = 1'b0;
    hold    = 1'b1;
    ped_req = 1'b1;
    cyc();
    reset   = 1'b1;
    hold    = 1'b0;
    ped_req = 1'b0;
    check("r_phase", phase, 0);
    check("r_walk", walk, 0);
    check("r_pend", ped_pending, 0);
    check("r_v", vertical_light, 2'b11);
    repeat (3) cyc();
    check("r_vg_end", phase, 0);
    cyc();
    check("r_vyellow", phase, 1);

    // Illegal state code 7 recovers to a full-length V_GREEN
    force dut.state_q = 3'd7;
    #1;
    release dut.state_q;
    check("i_phase7", phase, 7);
    check("i_h_red", horizontal_light, 2'b00);
    check("i_v_red", vertical_light, 2'b00);
    check("i_walk", walk, 0);
    cyc();
    check("i_recover", phase, 0);
    repeat (3) cyc();
    check("i_vg_end", phase, 0);
    cyc();
    check("i_vyellow", phase, 1);

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_timed.md
TRAFFIC_TIMED -- requirements
Module: traffic_timed

Interface
REQ-001 Parameter G_TICKS, default 8: cycles each direction stays GREEN; SHALL be >= 1.
REQ-002 Parameter Y_TICKS, default 3: cycles each direction stays YELLOW; SHALL be >= 1.
REQ-003 Parameter R_TICKS, default 1: all-red clearance cycles; SHALL be >= 1.
REQ-004 Parameter W_TICKS, default 5: pedestrian walk cycles; SHALL be >= 1.
REQ-005 Parameter CNT_W, default 8: timer width; SHALL hold max(G,Y,R,W)_TICKS-1, checked at elaboration.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 hold  input  1  high freezes timer and current phase.
REQ-009 ped_req  input  1  pedestrian request pulse or level; sampled every cycle.
REQ-010 horizontal_light  output  2  RED=00, YELLOW=10, GREEN=11.
REQ-011 vertical_light  output  2  same encoding.
REQ-012 walk  output  1  high only in PED_WALK.
REQ-013 ped_pending  output  1  latched, not-yet-served request.
REQ-014 phase  output  3  current state code, for debug.

Function
REQ-015 States, codes 0-6: V_GREEN(H RED,V GREEN), V_YELLOW(H RED,V YELLOW), ALL_RED_1, H_GREEN(H GREEN,V RED), H_YELLOW(H YELLOW,V RED), ALL_RED_2, PED_WALK(both RED).
REQ-016 Order: V_GREEN->V_YELLOW->ALL_RED_1->H_GREEN->H_YELLOW->ALL_RED_2->V_GREEN; ALL_RED_2 goes to PED_WALK instead if ped_pending=1; PED_WALK->V_GREEN.
REQ-017 On entering a phase of duration N, timer loads N-1; each cycle with hold=0 and timer>0 it decrements by 1.
REQ-018 Phase advances on the edge where timer=0 and hold=0; with hold low throughout, each phase lasts exactly N cycles.
REQ-019 hold=1 freezes timer and state in every phase, including when timer=0; release resumes with no cycles lost or added.
REQ-020 Lights, walk and phase are combinational decodes of registered state; no output glitch on phase change.
REQ-021 Code 7 is illegal; if reached, SHALL go to V_GREEN next cycle with timer G_TICKS-1; outputs both RED meanwhile.
REQ-022 ped_pending sets on any cycle with ped_req=1 and clears on the ALL_RED_2->PED_WALK edge.
REQ-023 If ped_req=1 on the ALL_RED_2->PED_WALK edge, clear wins: the request is served by that walk.
REQ-024 ped_req during PED_WALK is ignored; the walk already serves it.
REQ-025 Never both directions non-RED; never walk=1 unless both RED.
REQ-026 Timer never wraps below 0; decrement is gated by timer>0.

Reset
REQ-027 With reset=0 at a rising edge: state V_GREEN, timer G_TICKS-1, ped_pending 0; next outputs H RED, V GREEN, walk 0, phase 0.
REQ-028 Reset has priority over hold and ped_req and aborts any phase, including PED_WALK, at once.
REQ-029 Outputs before the first reset edge are undefined; the bench SHALL NOT check them.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the light encodings RED/YELLOW/GREEN and the 3-bit state enumeration, for reuse by other traffic blocks.
REQ-031 One sub-module phase_timer (parameter CNT_W; load, load_val, hold, expired) SHALL hold the down-counter; FSM and decode stay in traffic_timed.

Verification (G=4,Y=2,R=1,W=3)
REQ-032 Reset release, hold=0, no ped_req -> phase sequence 0x4,1x2,2x1,3x4,4x2,5x1, then repeats; period 14 cycles.
REQ-033 ped_req pulse during H_GREEN -> ped_pending=1; after ALL_RED_2, PED_WALK for 3 cycles with walk=1 and both lights 00; then V_GREEN; period 17.
REQ-034 hold=1 for 5 cycles mid V_GREEN (timer=2) -> V_GREEN lasts 9 cycles total; hold at timer=0 extends the phase identically.
REQ-035 ped_req high on the ALL_RED_2->PED_WALK edge -> ped_pending=0 after the edge; exactly one walk served.
REQ-036 reset=0 for one cycle during PED_WALK -> next cycle phase 0, walk 0, ped_pending 0, V GREEN.
REQ-037 Force state code 7 -> next cycle phase 0; assertion over all runs: no cycle with both lights non-00, none with walk=1 and a light non-00.
